// File: rtl/pe_pkg.sv
// pe_pkg: definitions shared by the PE-row multicast controller.
//   - state_e   : controller mode encoding (CFG=0, RUN=1, DRAIN=2)
//   - BITWIDTH_DEF / ID_WIDTH_DEF : default data and tag widths
//   - BCAST_TAG : all-ones broadcast tag at the default tag width
package pe_pkg;

   localparam int BITWIDTH_DEF = 16;
   localparam int ID_WIDTH_DEF = 4;

   localparam logic [ID_WIDTH_DEF-1:0] BCAST_TAG = '1;

   typedef enum logic [1:0] {
      CFG   = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/mcast_id_table.sv
// mcast_id_table: per-PE ID registers plus the combinational tag match.
// Ports:
//   clk, rstb          clock, async active-low reset (clears every ID to 0)
//   we, addr, wid      write port; an addr with no matching PE is ignored
//   tag                tag to compare against every entry
//   mask               bit i set when tag equals the ID of PE i
// Build option MCAST_BROADCAST_EN: the all-ones tag matches every PE.
module mcast_id_table
   import pe_pkg::*;
#(
   parameter int NUM_PE       = 4,
   parameter int ID_WIDTH     = ID_WIDTH_DEF,
   parameter int PE_IDX_WIDTH = 2
) (
   input  logic                    clk,
   input  logic                    rstb,
   input  logic                    we,
   input  logic [PE_IDX_WIDTH-1:0] addr,
   input  logic [ID_WIDTH-1:0]     wid,
   input  logic [ID_WIDTH-1:0]     tag,
   output logic [NUM_PE-1:0]       mask
);

   logic [ID_WIDTH-1:0] id_q [NUM_PE];

   // Decoding against each index drops out-of-range addresses naturally.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         for (int i = 0; i < NUM_PE; i++) id_q[i] <= '0;
      end else if (we) begin
         for (int i = 0; i < NUM_PE; i++) begin
            if (addr == PE_IDX_WIDTH'(i)) id_q[i] <= wid;
         end
      end
   end

   always_comb begin
      mask = '0;
      for (int i = 0; i < NUM_PE; i++) mask[i] = (tag == id_q[i]);
`ifdef MCAST_BROADCAST_EN
      if (tag == {ID_WIDTH{1'b1}}) mask = '1;
`endif
   end

endmodule

// File: rtl/pe_multicast_ctrl.sv
// pe_multicast_ctrl: delivers tagged ifmap/filter words from the global
// buffer to one row of PEs, loading all targeted PEs on the same cycle.
// Ports:
//   clk, rstb                     clock, async active-low reset
//   start, stop                   mode pulses (CFG->RUN, RUN->DRAIN)
//   cfg_we, cfg_addr, cfg_id      ID table write, honoured in CFG only
//   in_valid/in_ready             input word handshake
//   in_is_filter, in_tag, in_data input word fields
//   pe_ready                      per-PE ready flags
//   pe_ifmap_enable/_filter_enable per-PE load strobes
//   pe_data                       staged word broadcast to all PEs
//   busy                          high in RUN and DRAIN
//   drop_pulse                    staged word matched no PE
// Build option MCAST_BROADCAST_EN (in mcast_id_table): all-ones tag targets
// every PE.
//
// state | meaning
// CFG   | ID table writable, no input accepted
// RUN   | streaming words through the single-entry stage
// DRAIN | no new input; wait for the stage to empty, then CFG
module pe_multicast_ctrl
   import pe_pkg::*;
#(
   parameter int BITWIDTH     = BITWIDTH_DEF,
   parameter int NUM_PE       = 4,
   parameter int ID_WIDTH     = ID_WIDTH_DEF,
   parameter int PE_IDX_WIDTH = 2
) (
   input  logic                    clk,
   input  logic                    rstb,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    cfg_we,
   input  logic [PE_IDX_WIDTH-1:0] cfg_addr,
   input  logic [ID_WIDTH-1:0]     cfg_id,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_is_filter,
   input  logic [ID_WIDTH-1:0]     in_tag,
   input  logic [BITWIDTH-1:0]     in_data,
   input  logic [NUM_PE-1:0]       pe_ready,
   output logic [NUM_PE-1:0]       pe_ifmap_enable,
   output logic [NUM_PE-1:0]       pe_filter_enable,
   output logic [BITWIDTH-1:0]     pe_data,
   output logic                    busy,
   output logic                    drop_pulse
);

   state_e              state_q, state_d;
   logic                stage_valid_q, stage_valid_d;
   logic                stage_filter_q, stage_filter_d;
   logic [NUM_PE-1:0]   stage_mask_q, stage_mask_d;
   logic [BITWIDTH-1:0] data_q, data_d;
   logic [NUM_PE-1:0]   match_mask;
   logic                fire, accept;

   mcast_id_table #(
      .NUM_PE       (NUM_PE),
      .ID_WIDTH     (ID_WIDTH),
      .PE_IDX_WIDTH (PE_IDX_WIDTH)
   ) u_id_table (
      .clk  (clk),
      .rstb (rstb),
      .we   (cfg_we && (state_q == CFG)),
      .addr (cfg_addr),
      .wid  (cfg_id),
      .tag  (in_tag),
      .mask (match_mask)
   );

   // All-or-nothing delivery: every targeted PE must be ready at once.
   assign fire       = stage_valid_q && (stage_mask_q != '0) &&
                       ((stage_mask_q & ~pe_ready) == '0);
   assign drop_pulse = stage_valid_q && (stage_mask_q == '0);
   assign in_ready   = (state_q == RUN) && (!stage_valid_q || fire);
   assign accept     = in_valid && in_ready;

   assign pe_ifmap_enable  = (fire && !stage_filter_q) ? stage_mask_q : '0;
   assign pe_filter_enable = (fire &&  stage_filter_q) ? stage_mask_q : '0;
   assign pe_data          = data_q;
   assign busy             = (state_q != CFG);

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) state_q <= CFG;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CFG:     if (start)          state_d = RUN;
         RUN:     if (stop)           state_d = DRAIN;
         DRAIN:   if (!stage_valid_q) state_d = CFG;
         default:                     state_d = CFG;
      endcase
   end

   // A freed slot may be refilled on the same edge (back-to-back).
   always_comb begin
      stage_valid_d  = stage_valid_q;
      stage_filter_d = stage_filter_q;
      stage_mask_d   = stage_mask_q;
      data_d         = data_q;
      if (fire || drop_pulse) stage_valid_d = 1'b0;
      if (accept) begin
         stage_valid_d  = 1'b1;
         stage_filter_d = in_is_filter;
         stage_mask_d   = match_mask;
         data_d         = in_data;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         stage_valid_q  <= 1'b0;
         stage_filter_q <= 1'b0;
         stage_mask_q   <= '0;
         data_q         <= '0;
      end else begin
         stage_valid_q  <= stage_valid_d;
         stage_filter_q <= stage_filter_d;
         stage_mask_q   <= stage_mask_d;
         data_q         <= data_d;
      end
   end

endmodule
